// File: rtl/ds_pad_mapper.sv
// DualShock poll-frame to JAMMA button mapper: frame validation, per-button confirm
// filtering, left-stick to d-pad conversion with hysteresis, and a link watchdog.
module ds_pad_mapper #(
   parameter int unsigned FREQ       = 21_600_000,
   parameter int unsigned TIMEOUT_MS = 100,
   parameter int unsigned CONFIRM    = 2,
   parameter int unsigned THRESH_LO  = 64,
   parameter int unsigned THRESH_HI  = 192,
   parameter int unsigned HYST       = 16
) (
   input  logic        clk,
   input  logic        I_RSTn,
   input  logic        I_FRAME_VLD,
   input  logic [7:0]  I_ID,
   input  logic [7:0]  I_BTN_LO,
   input  logic [7:0]  I_BTN_HI,
   input  logic [7:0]  I_LX,
   input  logic [7:0]  I_LY,
   output logic [13:0] O_BTN,
   output logic [13:0] O_PRESS,
   output logic        O_CONNECTED,
   output logic        O_ANALOG
);

   localparam int unsigned NBTN        = 14;
   localparam int unsigned CNT_W       = 3;
   localparam int unsigned TIMEOUT_CYC = FREQ / 1000 * TIMEOUT_MS;
   localparam int unsigned WD_W        = $clog2(TIMEOUT_CYC + 1);
   localparam logic [7:0]  ID_DIG      = 8'h41;
   localparam logic [7:0]  ID_ANA      = 8'h73;
   localparam logic [7:0]  LP_LO       = 8'(THRESH_LO);
   localparam logic [7:0]  LP_HI       = 8'(THRESH_HI);
   localparam logic [7:0]  LP_NEG_EXIT = 8'(THRESH_LO + HYST);
   localparam logic [7:0]  LP_POS_EXIT = 8'(THRESH_HI - HYST);

   typedef enum logic [1:0] {AX_CENTRE, AX_NEG, AX_POS} axis_t;

   // One axis step; NEG<->POS transitions use the plain entry thresholds.
   function automatic axis_t axis_step(input axis_t cur, input logic [7:0] v);
      axis_t nxt;
      nxt = cur;
      case (cur)
         AX_CENTRE: begin
            if (v < LP_LO)      nxt = AX_NEG;
            else if (v > LP_HI) nxt = AX_POS;
         end
         AX_NEG: begin
            if (v > LP_HI)             nxt = AX_POS;
            else if (v >= LP_NEG_EXIT) nxt = AX_CENTRE;
         end
         AX_POS: begin
            if (v < LP_LO)             nxt = AX_NEG;
            else if (v <= LP_POS_EXIT) nxt = AX_CENTRE;
         end
         default: nxt = AX_CENTRE;
      endcase
      return nxt;
   endfunction

   logic [15:0]      r_raw;
   logic [7:0]       r_lx, r_ly;
   logic             r_s1_vld, r_s1_analog;
   logic             r_analog, r_connected;
   logic [WD_W-1:0]  r_wd;
   axis_t            r_ax_x, r_ax_y;
   logic [NBTN-1:0]  r_btn, r_press;
   logic [CNT_W-1:0] r_cnt [NBTN];

   logic             w_is_ana, w_accept, w_expired, w_clear;
   axis_t            w_ax_x_nxt, w_ax_y_nxt;
   logic             w_up, w_down, w_left, w_right;
   logic [NBTN-1:0]  w_cand, w_btn_nxt;
   logic [CNT_W-1:0] w_cnt_nxt [NBTN];
   logic             w_unused_l3r3;

   assign w_is_ana      = (I_ID == ID_ANA);
   assign w_accept      = I_FRAME_VLD & ((I_ID == ID_DIG) | w_is_ana);
   assign w_expired     = (r_wd == '0);
   assign w_clear       = w_expired & ~w_accept;
   assign w_unused_l3r3 = ^r_raw[2:1];

   // Stage 2: axis update, button map, SOCD and confirm filter
   always_comb begin
      w_ax_x_nxt = AX_CENTRE;
      w_ax_y_nxt = AX_CENTRE;
      if (r_s1_analog) begin
         w_ax_x_nxt = axis_step(r_ax_x, r_lx);
         w_ax_y_nxt = axis_step(r_ax_y, r_ly);
      end
      w_up    = r_raw[4] | (w_ax_y_nxt == AX_NEG);
      w_down  = r_raw[6] | (w_ax_y_nxt == AX_POS);
      w_left  = r_raw[7] | (w_ax_x_nxt == AX_NEG);
      w_right = r_raw[5] | (w_ax_x_nxt == AX_POS);

      w_cand     = '0;
      w_cand[0]  = r_raw[0];
      w_cand[1]  = r_raw[3];
      w_cand[2]  = w_up & ~w_down;
      w_cand[3]  = w_down & ~w_up;
      w_cand[4]  = w_left & ~w_right;
      w_cand[5]  = w_right & ~w_left;
      w_cand[6]  = r_raw[13];
      w_cand[7]  = r_raw[14];
      w_cand[8]  = r_raw[12];
      w_cand[9]  = r_raw[15];
      w_cand[10] = r_raw[10] | r_raw[8];
      w_cand[11] = r_raw[11] | r_raw[9];

      w_btn_nxt = r_btn;
      w_cnt_nxt = r_cnt;
      for (int i = 0; i < int'(NBTN); i++) begin
         if (w_cand[i] == r_btn[i]) begin
            w_cnt_nxt[i] = '0;
         end else if (r_cnt[i] + CNT_W'(1) == CNT_W'(CONFIRM)) begin
            w_btn_nxt[i] = w_cand[i];
            w_cnt_nxt[i] = '0;
         end else begin
            w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!I_RSTn) begin
         r_raw       <= '0;
         r_lx        <= '0;
         r_ly        <= '0;
         r_s1_vld    <= 1'b0;
         r_s1_analog <= 1'b0;
         r_analog    <= 1'b0;
         r_connected <= 1'b0;
         r_wd        <= '0;
         r_ax_x      <= AX_CENTRE;
         r_ax_y      <= AX_CENTRE;
         r_btn       <= '0;
         r_press     <= '0;
         r_cnt       <= '{default: '0};
      end else begin
         r_s1_vld <= w_accept;
         if (w_accept) begin
            r_raw       <= ~{I_BTN_HI, I_BTN_LO};
            r_lx        <= I_LX;
            r_ly        <= I_LY;
            r_s1_analog <= w_is_ana;
            r_analog    <= w_is_ana;
            r_wd        <= WD_W'(TIMEOUT_CYC);
            r_connected <= 1'b1;
         end else if (w_expired) begin
            r_connected <= 1'b0;
         end else begin
            r_wd <= r_wd - WD_W'(1);
         end

         // Link loss drops everything silently; reconnect starts from scratch
         r_press <= '0;
         if (w_clear) begin
            r_btn  <= '0;
            r_cnt  <= '{default: '0};
            r_ax_x <= AX_CENTRE;
            r_ax_y <= AX_CENTRE;
         end else if (r_s1_vld) begin
            r_btn   <= w_btn_nxt;
            r_press <= w_btn_nxt & ~r_btn;
            r_cnt   <= w_cnt_nxt;
            r_ax_x  <= w_ax_x_nxt;
            r_ax_y  <= w_ax_y_nxt;
         end
      end
   end

   assign O_BTN       = r_btn;
   assign O_PRESS     = r_press;
   assign O_CONNECTED = r_connected;
   assign O_ANALOG    = r_analog;

endmodule

// File: tb/tb_ds_pad_mapper.sv
// Bench for ds_pad_mapper: table of frames with hand-derived expected buttons, scoreboard
// checked two edges after each accepted strobe, plus timeout and mid-stream reset sequences.
module tb_ds_pad_mapper;

   localparam int unsigned FREQ       = 10_000;
   localparam int unsigned TIMEOUT_MS = 100;

   logic        clk = 1'b0;
   logic        rstn, vld;
   logic [7:0]  id, lo, hi, lx, ly;
   logic [13:0] btn, press;
   logic        conn, ana;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [13:0] btn;
      logic [13:0] press;
   } exp_t;

   typedef struct {
      logic [7:0]  id, lo, hi, lx, ly;
      logic [13:0] btn, press;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[$];

   always #5 clk = ~clk;

   ds_pad_mapper #(
      .FREQ(FREQ), .TIMEOUT_MS(TIMEOUT_MS), .CONFIRM(2),
      .THRESH_LO(64), .THRESH_HI(192), .HYST(16)
   ) dut (
      .clk(clk), .I_RSTn(rstn), .I_FRAME_VLD(vld), .I_ID(id),
      .I_BTN_LO(lo), .I_BTN_HI(hi), .I_LX(lx), .I_LY(ly),
      .O_BTN(btn), .O_PRESS(press), .O_CONNECTED(conn), .O_ANALOG(ana)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // Bench's own view of which strobes are accepted and when their result is due
   logic p1 = 1'b0, p2 = 1'b0;
   always @(posedge clk) begin
      p1 <= vld && rstn && (id == 8'h41 || id == 8'h73);
      p2 <= p1;
   end

   always @(negedge clk) begin : mon
      exp_t e;
      if (p2) begin
         if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("btn", 32'(btn), 32'(e.btn));
            check("press", 32'(press), 32'(e.press));
         end
      end else if (rstn) begin
         check("press_idle", 32'(press), 32'd0);
      end
   end

   task automatic frame(input logic [7:0] f_id, input logic [7:0] f_lo, input logic [7:0] f_hi,
                        input logic [7:0] f_lx, input logic [7:0] f_ly,
                        input logic [13:0] e_btn, input logic [13:0] e_press);
      exp_t e;
      @(negedge clk);
      id = f_id; lo = f_lo; hi = f_hi; lx = f_lx; ly = f_ly; vld = 1'b1;
      if (f_id == 8'h41 || f_id == 8'h73) begin
         e.btn   = e_btn;
         e.press = e_press;
         sb.push_back(e);
      end
      @(negedge clk);
      vld = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   function automatic void add(input logic [7:0] a_id, input logic [7:0] a_lo, input logic [7:0] a_hi,
                               input logic [7:0] a_lx, input logic [7:0] a_ly,
                               input logic [13:0] a_btn, input logic [13:0] a_press);
      vec_t v;
      v.id = a_id; v.lo = a_lo; v.hi = a_hi; v.lx = a_lx; v.ly = a_ly;
      v.btn = a_btn; v.press = a_press;
      tbl.push_back(v);
   endfunction

   initial begin
      rstn = 1'b0; vld = 1'b0; id = 8'h00; lo = 8'hFF; hi = 8'hFF; lx = 8'h80; ly = 8'h80;

      // confirm on up, with a dropped frame in between
      add(8'h41, 8'hEF, 8'hFF, 8'h80, 8'h80, 14'h000, 14'h000);
      add(8'h00, 8'hEF, 8'hFF, 8'h80, 8'h80, 14'h000, 14'h000);
      add(8'h41, 8'hEF, 8'hFF, 8'h80, 8'h80, 14'h004, 14'h004);
      // one-frame start glitch
      add(8'h41, 8'hFF, 8'hFF, 8'h80, 8'h80, 14'h004, 14'h000);
      add(8'h41, 8'hF7, 8'hFF, 8'h80, 8'h80, 14'h000, 14'h000);
      add(8'h41, 8'hFF, 8'hFF, 8'h80, 8'h80, 14'h000, 14'h000);
      // stick left with hysteresis
      add(8'h73, 8'hFF, 8'hFF, 8'h80, 8'h80, 14'h000, 14'h000);
      add(8'h73, 8'hFF, 8'hFF, 8'h30, 8'h80, 14'h000, 14'h000);
      add(8'h73, 8'hFF, 8'hFF, 8'h30, 8'h80, 14'h010, 14'h010);
      add(8'h73, 8'hFF, 8'hFF, 8'h48, 8'h80, 14'h010, 14'h000);
      add(8'h73, 8'hFF, 8'hFF, 8'h50, 8'h80, 14'h010, 14'h000);
      add(8'h73, 8'hFF, 8'hFF, 8'h50, 8'h80, 14'h000, 14'h000);
      // SOCD: dpad up with stick down
      add(8'h73, 8'hEF, 8'hFF, 8'h80, 8'hF0, 14'h000, 14'h000);
      add(8'h73, 8'hEF, 8'hFF, 8'h80, 8'hF0, 14'h000, 14'h000);
      // button map: select, O, L1 then start, X, Tri, Sq, R2 with dpad left+right
      add(8'h41, 8'hFE, 8'hDB, 8'h80, 8'h80, 14'h000, 14'h000);
      add(8'h41, 8'hFE, 8'hDB, 8'h80, 8'h80, 14'h441, 14'h441);
      add(8'h41, 8'h57, 8'h2D, 8'h80, 8'h80, 14'h441, 14'h000);
      add(8'h41, 8'h57, 8'h2D, 8'h80, 8'h80, 14'hB82, 14'hB82);
      // digital frame forces the axis back to centre
      add(8'h73, 8'hFF, 8'hFF, 8'h30, 8'h80, 14'hB82, 14'h000);
      add(8'h41, 8'hFF, 8'hFF, 8'h30, 8'h80, 14'h000, 14'h000);
      add(8'h73, 8'hFF, 8'hFF, 8'h30, 8'h80, 14'h000, 14'h000);
      add(8'h73, 8'hFF, 8'hFF, 8'h30, 8'h80, 14'h010, 14'h010);
      // NEG straight to POS, then POS exit boundary
      add(8'h73, 8'hFF, 8'hFF, 8'hC8, 8'h80, 14'h010, 14'h000);
      add(8'h73, 8'hFF, 8'hFF, 8'hC8, 8'h80, 14'h020, 14'h020);
      add(8'h73, 8'hFF, 8'hFF, 8'hB8, 8'h80, 14'h020, 14'h000);
      add(8'h73, 8'hFF, 8'hFF, 8'hB0, 8'h80, 14'h020, 14'h000);
      add(8'h73, 8'hFF, 8'hFF, 8'hB0, 8'h80, 14'h000, 14'h000);
      // exact thresholds stay centre; one below enters NEG
      add(8'h73, 8'hFF, 8'hFF, 8'h40, 8'hC0, 14'h000, 14'h000);
      add(8'h73, 8'hFF, 8'hFF, 8'h40, 8'hC0, 14'h000, 14'h000);
      add(8'h73, 8'hFF, 8'hFF, 8'h3F, 8'h80, 14'h000, 14'h000);
      add(8'h73, 8'hFF, 8'hFF, 8'h3F, 8'h80, 14'h010, 14'h010);
      // hold start for the timeout sequence
      add(8'h41, 8'hF7, 8'hFF, 8'h3F, 8'h80, 14'h010, 14'h000);
      add(8'h41, 8'hF7, 8'hFF, 8'h3F, 8'h80, 14'h002, 14'h002);

      repeat (3) @(negedge clk);
      check("rst_btn", 32'(btn), 32'd0);
      check("rst_press", 32'(press), 32'd0);
      check("rst_conn", 32'(conn), 32'd0);
      check("rst_analog", 32'(ana), 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      check("idle_conn", 32'(conn), 32'd0);

      for (int i = 0; i < tbl.size(); i++)
         frame(tbl[i].id, tbl[i].lo, tbl[i].hi, tbl[i].lx, tbl[i].ly, tbl[i].btn, tbl[i].press);
      check("table_conn", 32'(conn), 32'd1);
      check("table_analog", 32'(ana), 32'd0);

      // only bad-ID frames with start held: link must time out
      for (int i = 0; i < 19; i++) begin
         frame(8'hFF, 8'hF7, 8'hFF, 8'h80, 8'h80, 14'h000, 14'h000);
         repeat (44) @(negedge clk);
      end
      check("pre_timeout_conn", 32'(conn), 32'd1);
      check("pre_timeout_btn", 32'(btn), 32'h002);
      for (int i = 0; i < 3; i++) begin
         frame(8'hFF, 8'hF7, 8'hFF, 8'h80, 8'h80, 14'h000, 14'h000);
         repeat (44) @(negedge clk);
      end
      check("timeout_conn", 32'(conn), 32'd0);
      check("timeout_btn", 32'(btn), 32'd0);

      // reconnect needs fresh confirmation
      frame(8'h73, 8'hF7, 8'hFF, 8'h80, 8'h80, 14'h000, 14'h000);
      check("reconn_conn", 32'(conn), 32'd1);
      check("reconn_analog", 32'(ana), 32'd1);
      frame(8'h73, 8'hF7, 8'hFF, 8'h80, 8'h80, 14'h002, 14'h002);

      // reset between two confirming frames, with a strobe during reset
      frame(8'h41, 8'hEF, 8'hFF, 8'h80, 8'h80, 14'h002, 14'h000);
      @(negedge clk);
      rstn = 1'b0; vld = 1'b1; id = 8'h41; lo = 8'hEF;
      @(negedge clk);
      vld = 1'b0;
      repeat (2) @(negedge clk);
      check("mid_rst_btn", 32'(btn), 32'd0);
      check("mid_rst_press", 32'(press), 32'd0);
      check("mid_rst_conn", 32'(conn), 32'd0);
      check("mid_rst_analog", 32'(ana), 32'd0);
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      check("post_rst_conn", 32'(conn), 32'd0);
      frame(8'h41, 8'hEF, 8'hFF, 8'h80, 8'h80, 14'h000, 14'h000);
      check("post_rst_conn1", 32'(conn), 32'd1);
      frame(8'h41, 8'hEF, 8'hFF, 8'h80, 8'h80, 14'h004, 14'h004);

      repeat (5) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
